// File: rtl/tdm_demux_1to8_pkg.sv
// Shared definitions for the 1-to-8 TDM demultiplexer.
// Holds the FSM encoding, the channel/slot constants and the slot one-hot decode helper.
package tdm_demux_1to8_pkg;

    localparam int NUM_CH = 8;
    localparam int SLOT_W = 3;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_COLLECT = 1'b1
    } state_t;

    // One-hot decode of a slot index, used for the channel strobe.
    function automatic logic [NUM_CH-1:0] slot_onehot(input logic [SLOT_W-1:0] s);
        logic [NUM_CH-1:0] one_s;
        one_s       = {{(NUM_CH-1){1'b0}}, 1'b1};
        slot_onehot = one_s << s;
    endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// 3-bit wrapping slot counter with clear (to 0) and load (to 1).
// Priority is clear, then load, then increment.
module tdm_slot_counter
    import tdm_demux_1to8_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              load1,
    input  logic              inc,
    output logic [SLOT_W-1:0] cnt
);

    // Slot index register; natural 3-bit wrap takes slot 7 back to 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= {SLOT_W{1'b0}};
        end else if (clr) begin
            cnt <= {SLOT_W{1'b0}};
        end else if (load1) begin
            cnt <= {{(SLOT_W-1){1'b0}}, 1'b1};
        end else if (inc) begin
            cnt <= cnt + {{(SLOT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt <= cnt;
        end
    end

endmodule

// File: rtl/tdm_demux_1to8.sv
// Serial TDM frame demultiplexer: collects 8 slots behind an in_sync marker
// and presents each completed frame in parallel, with strobe and error pulses.
module tdm_demux_1to8
    import tdm_demux_1to8_pkg::*;
#(
    parameter int NUM_CH = 8
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              in_bit,
    input  logic              in_sync,
    output logic [NUM_CH-1:0] out,
    output logic [NUM_CH-1:0] ch_strobe,
    output logic              frame_valid,
    output logic              frame_err,
    output logic [SLOT_W-1:0] slot
);

    generate
        if (NUM_CH != 8) begin : g_bad_num_ch
            $error("tdm_demux_1to8: only NUM_CH = 8 is supported");
        end
    endgenerate

    localparam logic [SLOT_W-1:0] LAST_SLOT = 3'd7;
    localparam logic [SLOT_W-1:0] FIRST_SLOT = 3'd0;

    state_t            state_r, state_s;
    logic [NUM_CH-2:0] shadow_r, shadow_s;
    logic [NUM_CH-1:0] out_r, out_s;
    logic [NUM_CH-1:0] strobe_r, strobe_s;
    logic              fv_r, fv_s;
    logic              fe_r, fe_s;
    logic              cnt_clr_s, cnt_load1_s, cnt_inc_s;
    logic [SLOT_W-1:0] slot_s;

    tdm_slot_counter u_slot_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr_s),
        .load1 (cnt_load1_s),
        .inc   (cnt_inc_s),
        .cnt   (slot_s)
    );

    // Next-state, shadow update and output-pulse decode for one accepted bit.
    always_comb begin
        state_s     = state_r;
        shadow_s    = shadow_r;
        out_s       = out_r;
        strobe_s    = {NUM_CH{1'b0}};
        fv_s        = 1'b0;
        fe_s        = 1'b0;
        cnt_clr_s   = 1'b0;
        cnt_load1_s = 1'b0;
        cnt_inc_s   = 1'b0;
        if (in_valid) begin
            case (state_r)
                ST_IDLE: begin
                    if (in_sync) begin
                        shadow_s[0] = in_bit;
                        strobe_s    = slot_onehot(FIRST_SLOT);
                        cnt_load1_s = 1'b1;
                        state_s     = ST_COLLECT;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_COLLECT: begin
                    if (in_sync) begin
                        // Sync anywhere but slot 0 aborts the partial frame and restarts it.
                        fe_s        = (slot_s != FIRST_SLOT);
                        shadow_s[0] = in_bit;
                        strobe_s    = slot_onehot(FIRST_SLOT);
                        cnt_load1_s = 1'b1;
                    end else if (slot_s == FIRST_SLOT) begin
                        fe_s      = 1'b1;
                        cnt_clr_s = 1'b1;
                        state_s   = ST_IDLE;
                    end else if (slot_s == LAST_SLOT) begin
                        out_s     = {in_bit, shadow_r};
                        fv_s      = 1'b1;
                        strobe_s  = slot_onehot(slot_s);
                        cnt_inc_s = 1'b1;
                    end else begin
                        shadow_s[slot_s] = in_bit;
                        strobe_s         = slot_onehot(slot_s);
                        cnt_inc_s        = 1'b1;
                    end
                end
                default: begin
                    cnt_clr_s = 1'b1;
                    state_s   = ST_IDLE;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // State, shadow and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            shadow_r <= {(NUM_CH-1){1'b0}};
            out_r    <= {NUM_CH{1'b0}};
            strobe_r <= {NUM_CH{1'b0}};
            fv_r     <= 1'b0;
            fe_r     <= 1'b0;
        end else begin
            state_r  <= state_s;
            shadow_r <= shadow_s;
            out_r    <= out_s;
            strobe_r <= strobe_s;
            fv_r     <= fv_s;
            fe_r     <= fe_s;
        end
    end

    assign out         = out_r;
    assign ch_strobe   = strobe_r;
    assign frame_valid = fv_r;
    assign frame_err   = fe_r;
    assign slot        = slot_s;

endmodule

// File: tb/tb_tdm_demux_1to8.sv
// Self-checking bench for tdm_demux_1to8: directed vector table, hand-written
// corner sequences and randomized traffic against a frame-level reference model.
module tb_tdm_demux_1to8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_bit = 1'b0;
    logic       in_sync = 1'b0;
    logic [7:0] out;
    logic [7:0] ch_strobe;
    logic       frame_valid;
    logic       frame_err;
    logic [2:0] slot;

    int n_checks = 0;
    int n_errors = 0;
    int cycle = 0;
    int fv_cycles[$];

    // Reference model: frame position as plain integers and a bit array.
    bit       m_in_frame;
    int       m_slot;
    bit       m_bits[8];
    bit [7:0] m_out;
    bit [7:0] m_strobe;
    bit       m_fv;
    bit       m_fe;

    tdm_demux_1to8 #(.NUM_CH(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit),
        .in_sync(in_sync), .out(out), .ch_strobe(ch_strobe),
        .frame_valid(frame_valid), .frame_err(frame_err), .slot(slot)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       v;
        bit       b;
        bit       s;
        bit [7:0] e_out;
        bit [7:0] e_strobe;
        bit       e_fv;
        bit [2:0] e_slot;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cycle, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_in_frame = 1'b0;
        m_slot     = 0;
        m_out      = 8'h00;
        m_strobe   = 8'h00;
        m_fv       = 1'b0;
        m_fe       = 1'b0;
        for (int k = 0; k < 8; k++) m_bits[k] = 1'b0;
    endfunction

    function automatic void model_start(input bit b);
        m_bits[0]  = b;
        m_slot     = 1;
        m_in_frame = 1'b1;
        m_strobe   = 8'h01;
    endfunction

    function automatic void model_step(input bit v, input bit b, input bit s);
        m_strobe = 8'h00;
        m_fv     = 1'b0;
        m_fe     = 1'b0;
        if (v) begin
            if (!m_in_frame) begin
                if (s) model_start(b);
            end else if (s) begin
                m_fe = (m_slot != 0);
                model_start(b);
            end else if (m_slot == 0) begin
                m_fe       = 1'b1;
                m_in_frame = 1'b0;
            end else begin
                m_bits[m_slot] = b;
                m_strobe       = 8'(1 << m_slot);
                if (m_slot == 7) begin
                    for (int k = 0; k < 8; k++) m_out[k] = m_bits[k];
                    m_fv   = 1'b1;
                    m_slot = 0;
                end else begin
                    m_slot = m_slot + 1;
                end
            end
        end
    endfunction

    task automatic check_model();
        chk("out", 32'(out), 32'(m_out));
        chk("ch_strobe", 32'(ch_strobe), 32'(m_strobe));
        chk("frame_valid", 32'(frame_valid), 32'(m_fv));
        chk("frame_err", 32'(frame_err), 32'(m_fe));
        chk("slot", 32'(slot), 32'(m_slot % 8));
    endtask

    task automatic step(input bit v, input bit b, input bit s);
        @(negedge clk);
        in_valid = v;
        in_bit   = b;
        in_sync  = s;
        @(posedge clk);
        #1;
        cycle++;
        model_step(v, b, s);
        if (frame_valid === 1'b1) fv_cycles.push_back(cycle);
        check_model();
    endtask

    task automatic send_frame(input logic [7:0] val, input int gap);
        for (int k = 0; k < 8; k++) begin
            step(1'b1, val[k], k == 0);
            if (k != 7) for (int g = 0; g < gap; g++) step(1'b0, $urandom_range(0, 1), $urandom_range(0, 1));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_out", 32'(out), 32'h0);
        chk("rst_strobe", 32'(ch_strobe), 32'h0);
        chk("rst_fv_fe", 32'({frame_valid, frame_err}), 32'h0);
        chk("rst_slot", 32'(slot), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        vec_t vecs[10];
        logic [7:0] bits_4d;
        int nv;
        bit s;

        model_reset();
        #12;
        do_reset();

        // Directed table: one noise bit in IDLE, then the 0x4D frame, then one idle cycle.
        bits_4d = 8'h4D;
        vecs[0] = '{v:1'b1, b:1'b1, s:1'b0, e_out:8'h00, e_strobe:8'h00, e_fv:1'b0, e_slot:3'd0};
        for (int k = 0; k < 8; k++)
            vecs[k+1] = '{v:1'b1, b:bits_4d[k], s:(k == 0), e_out:(k == 7) ? 8'h4D : 8'h00,
                          e_strobe:8'(1 << k), e_fv:(k == 7), e_slot:3'((k + 1) % 8)};
        vecs[9] = '{v:1'b0, b:1'b0, s:1'b1, e_out:8'h4D, e_strobe:8'h00, e_fv:1'b0, e_slot:3'd0};
        for (int i = 0; i < 10; i++) begin
            step(vecs[i].v, vecs[i].b, vecs[i].s);
            chk("tbl_out", 32'(out), 32'(vecs[i].e_out));
            chk("tbl_strobe", 32'(ch_strobe), 32'(vecs[i].e_strobe));
            chk("tbl_fv", 32'(frame_valid), 32'(vecs[i].e_fv));
            chk("tbl_slot", 32'(slot), 32'(vecs[i].e_slot));
        end

        // Back-to-back frames: pulses exactly 8 cycles apart.
        fv_cycles.delete();
        send_frame(8'hA5, 0);
        chk("b2b_first", 32'(out), 32'hA5);
        send_frame(8'h3C, 0);
        chk("b2b_second", 32'(out), 32'h3C);
        chk("b2b_pulses", 32'(fv_cycles.size()), 32'd2);
        if (fv_cycles.size() == 2) chk("b2b_spacing", 32'(fv_cycles[1] - fv_cycles[0]), 32'd8);

        // Gapped frame gives the same result as the gapless one.
        send_frame(8'hA5, 3);
        chk("gap_out", 32'(out), 32'hA5);

        // Early sync at slot 4.
        for (int k = 0; k < 4; k++) step(1'b1, 1'b1, k == 0);
        step(1'b1, 1'b0, 1'b1);
        chk("early_err", 32'(frame_err), 32'h1);
        chk("early_slot", 32'(slot), 32'h1);
        chk("early_out", 32'(out), 32'hA5);
        for (int k = 1; k < 8; k++) step(1'b1, k[0], 1'b0);
        chk("early_next", 32'(out), 32'hAA);

        // Missing sync at slot 0 drops to IDLE; unsynced bits are ignored.
        step(1'b1, 1'b1, 1'b0);
        chk("nosync_err", 32'(frame_err), 32'h1);
        for (int k = 0; k < 10; k++) step(1'b1, 1'b1, 1'b0);
        chk("nosync_slot", 32'(slot), 32'h0);
        chk("nosync_out", 32'(out), 32'hAA);
        send_frame(8'h5A, 1);
        chk("resync_out", 32'(out), 32'h5A);

        // Reset mid-frame at slot 5, then unsynced bits.
        for (int k = 0; k < 5; k++) step(1'b1, 1'b1, k == 0);
        chk("mid_slot", 32'(slot), 32'h5);
        do_reset();
        fv_cycles.delete();
        for (int k = 0; k < 8; k++) step(1'b1, k[1], 1'b0);
        chk("postrst_fv", 32'(fv_cycles.size()), 32'd0);

        // Randomized traffic: mostly well-formed frames with occasional sync faults.
        for (int i = 0; i < 3000; i++) begin
            nv = $urandom_range(0, 3);
            if (m_slot == 0) s = ($urandom_range(0, 7) != 0);
            else s = ($urandom_range(0, 39) == 0);
            step(nv != 0, $urandom_range(0, 1), s);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
